// File: rtl/spoon_uart_line_tx_if.sv
// Byte stream from the pointing-device generator to the UART line stage.
// One-cycle write strobe with data; the sink never applies backpressure.
interface spoon_uart_line_tx_if;
  logic       write;
  logic [7:0] data;

  modport master (
    output write,
    output data
  );

  modport slave (
    input write,
    input data
  );
endinterface

// File: rtl/spoon_uart_line_tx.sv
// Serialises queued bytes as 8N1 UART frames on txd, LSB first.
// Optional SPOON_TX_FLUSH_ON_RTS_EN: rts flushes the FIFO and aborts the frame.
module spoon_uart_line_tx #(
  parameter int CLKS_PER_BIT    = 25000,
  parameter int CLKS_PER_BIT_OC = 20000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 overclock,
  input  logic                 rts,
  spoon_uart_line_tx_if.slave  serial_in,
  output logic                 txd,
  output logic                 busy,
  output logic                 overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXP = (CLKS_PER_BIT > CLKS_PER_BIT_OC) ?
                        CLKS_PER_BIT : CLKS_PER_BIT_OC;
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] P_NORM = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] P_OC   = CW'(CLKS_PER_BIT_OC);
  localparam logic [AW:0]   DEPTH  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] r_period;
  logic [CW-1:0] w_period_nxt;
  logic [CW-1:0] w_period_sel;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;

  logic          r_txd;
  logic          w_txd_nxt;
  logic          r_busy;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_flush;

`ifdef SPOON_TX_FLUSH_ON_RTS_EN
  assign w_flush = rts;
`else
  logic w_unused_rts;
  assign w_unused_rts = rts;
  assign w_flush      = 1'b0;
`endif

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == DEPTH);
  assign w_period_sel = overclock ? P_OC : P_NORM;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_pop        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_pop = !w_empty;
      end
      S_START: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = r_period - 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = r_period - 1'b1;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          w_pop       = !w_empty;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A pop always begins a fresh frame with the period latched now
    if (w_pop) begin
      w_state_nxt  = S_START;
      w_shift_nxt  = r_mem[r_rd_ptr];
      w_period_nxt = w_period_sel;
      w_cnt_nxt    = w_period_sel - 1'b1;
    end

    if (w_flush) begin
      w_state_nxt = S_IDLE;
      w_pop       = 1'b0;
    end
  end

  always_comb begin
    w_push = 1'b0;
    w_drop = 1'b0;
    if (serial_in.write && !w_flush) begin
      w_push = !w_full || w_pop;
      w_drop = w_full && !w_pop;
    end

    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    if (w_flush) begin
      w_count_nxt = '0;
    end
  end

  always_comb begin
    w_txd_nxt = 1'b1;
    unique case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= serial_in.data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_period   <= P_NORM;
      r_idx      <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_period   <= w_period_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign txd      = r_txd;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_spoon_uart_line_tx.sv
// Randomised bench for spoon_uart_line_tx against a frame-level line model.
// Short bit periods keep every frame to a few dozen cycles.
module tb_spoon_uart_line_tx;

  localparam int PN = 6;
  localparam int PO = 4;
  localparam int D  = 4;

  logic clk;
  logic reset_n;
  logic overclock;
  logic rts;
  logic txd;
  logic busy;
  logic overflow;

  spoon_uart_line_tx_if sif ();

  spoon_uart_line_tx #(
    .CLKS_PER_BIT    (PN),
    .CLKS_PER_BIT_OC (PO),
    .FIFO_DEPTH      (D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .overclock (overclock),
    .rts       (rts),
    .serial_in (sif.slave),
    .txd       (txd),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;

  logic [7:0] q[$];
  int         t;
  int         fstart;
  int         fper;
  logic [7:0] fbyte;
  bit         m_ovf;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  function automatic bit in_frame();
    return fper > 0 && t > fstart && t <= fstart + 10 * fper;
  endfunction

  function automatic int exp_txd();
    int k;
    if (!in_frame()) return 1;
    k = (t - fstart - 1) / fper;
    if (k == 0) return 0;
    if (k == 9) return 1;
    return int'(fbyte[k-1]);
  endfunction

  task automatic model_clear();
    q.delete();
    fper  = 0;
    m_ovf = 1'b0;
  endtask

  // One clock cycle: check outputs of this cycle, drive inputs, advance model
  task automatic cycle(input bit wr, input logic [7:0] d,
                       input bit oc, input bit r);
    chk("txd", int'(txd), exp_txd());
    chk("busy", int'(busy), int'(in_frame() || q.size() > 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    sif.write = wr;
    sif.data  = d;
    overclock = oc;
    rts       = r;
`ifdef SPOON_TX_FLUSH_ON_RTS_EN
    if (r) begin
      q.delete();
      fper = 0;
    end else begin
`else
    begin
`endif
      if (q.size() > 0 && (fper == 0 || t >= fstart + 10 * fper)) begin
        fbyte  = q.pop_front();
        fstart = t;
        fper   = oc ? PO : PN;
      end
      if (wr) begin
        if (q.size() < D) q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit oc);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, oc, 1'b0);
  endtask

  task automatic do_reset();
    sif.write = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    t         = 0;
    fstart    = 0;
    fbyte     = 8'h00;
    sif.write = 1'b0;
    sif.data  = 8'h00;
    overclock = 1'b0;
    rts       = 1'b0;
    reset_n   = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    cycle(1'b1, 8'hCD, 1'b0, 1'b0);
    idle(70, 1'b0);

    cycle(1'b1, 8'hC0, 1'b0, 1'b0);
    cycle(1'b1, 8'h85, 1'b0, 1'b0);
    cycle(1'b1, 8'h9F, 1'b0, 1'b0);
    idle(190, 1'b0);

    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
    idle(320, 1'b0);
    do_reset();

    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    idle(10, 1'b1);
    idle(120, 1'b0);

    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(2 + PN * 4 + 2, 1'b0);
    do_reset();
    idle(80, 1'b0);

    for (int i = 0; i < 20000; i++) begin
      bit         wr;
      bit         oc;
      bit         r;
      logic [7:0] d;
      wr = ($urandom_range(0, 29) == 0);
      oc = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 199) == 0);
      d  = 8'($urandom);
      if ($urandom_range(0, 3999) == 0) do_reset();
      else cycle(wr, d, oc, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
